// File: rtl/mips_core_pkg.sv
// Shared core types: reorder-buffer geometry and the per-entry payload record.
package mips_core_pkg;
  localparam int ROB_DEPTH      = 16;
  localparam int ROB_DEPTH_BITS = 4;
  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 32;

  typedef logic [ROB_DEPTH_BITS-1:0] rob_tag_t;

  // valid/done are held as separate vectors beside this array so they can be cleared by reset
  typedef struct packed {
    logic                  is_branch;
    logic                  is_jump_reg;
    logic                  dst_valid;
    logic [4:0]            dst_reg;
    logic [DATA_WIDTH-1:0] data;
    logic                  outcome;
    logic [ADDR_WIDTH-1:0] target;
  } rob_entry_t;
endpackage

// File: rtl/rob_commit_unit.sv
// Reorder buffer: in-order allocation at tail, out-of-order completion by tag,
// in-order retirement of at most one head entry per cycle.
module rob_commit_unit
  import mips_core_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_alloc_valid,
  input  logic                      i_alloc_is_branch,
  input  logic                      i_alloc_is_jump_reg,
  input  logic                      i_alloc_dst_valid,
  input  logic [4:0]                i_alloc_dst_reg,
  output logic [ROB_DEPTH_BITS-1:0] o_alloc_tag,
  input  logic                      i_wb_valid,
  input  logic [ROB_DEPTH_BITS-1:0] i_wb_tag,
  input  logic [DATA_WIDTH-1:0]     i_wb_data,
  input  logic                      i_wb_branch_outcome,
  input  logic [ADDR_WIDTH-1:0]     i_wb_jump_target,
  input  logic                      i_stall,
  input  logic                      i_flush,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [ROB_DEPTH_BITS:0]   o_count,
  output logic                      o_valid_commit,
  output logic                      o_commit_dst_valid,
  output logic [4:0]                o_commit_dst_reg,
  output logic [DATA_WIDTH-1:0]     o_commit_data,
  output logic                      o_valid_branch,
  output logic                      o_branch_outcome,
  output logic                      o_valid_jump_reg,
  output logic [ADDR_WIDTH-1:0]     o_jump_target
);
  localparam int                    CNT_W      = ROB_DEPTH_BITS + 1;
  localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(ROB_DEPTH);
  localparam rob_tag_t              TAG_ONE    = rob_tag_t'(1);

  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_done;
  rob_entry_t           r_entries [ROB_DEPTH];
  rob_tag_t             r_head;
  rob_tag_t             r_tail;
  logic [CNT_W-1:0]     r_count;

  logic       w_full;
  logic       w_accept;
  logic       w_wb_hit;
  logic       w_retire;
  rob_entry_t w_head_entry;

  // full comes from the occupancy count; head==tail alone cannot tell full from empty
  assign w_full       = (r_count == FULL_COUNT);
  assign w_accept     = i_alloc_valid & ~w_full & ~i_flush;
  assign w_wb_hit     = i_wb_valid & r_valid[i_wb_tag] & ~i_flush;
  assign w_retire     = r_valid[r_head] & r_done[r_head] & ~i_stall & ~i_flush;
  assign w_head_entry = r_entries[r_head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_tail          <= r_tail + TAG_ONE;
      end
      if (w_wb_hit) begin
        r_done[i_wb_tag] <= 1'b1;
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_head          <= r_head + TAG_ONE;
      end
      r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_retire);
    end
  end

  // Payload needs no reset: it is only ever read behind a set valid bit.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_entries[r_tail].is_branch   <= i_alloc_is_branch;
      r_entries[r_tail].is_jump_reg <= i_alloc_is_jump_reg;
      r_entries[r_tail].dst_valid   <= i_alloc_dst_valid;
      r_entries[r_tail].dst_reg     <= i_alloc_dst_reg;
    end
    if (w_wb_hit) begin
      r_entries[i_wb_tag].data    <= i_wb_data;
      r_entries[i_wb_tag].outcome <= i_wb_branch_outcome;
      r_entries[i_wb_tag].target  <= i_wb_jump_target;
    end
  end

  assign o_alloc_tag        = r_tail;
  assign o_full             = w_full;
  assign o_empty            = (r_count == '0);
  assign o_count            = r_count;
  assign o_valid_commit     = w_retire;
  assign o_commit_dst_valid = w_retire & w_head_entry.dst_valid;
  assign o_commit_dst_reg   = w_retire ? w_head_entry.dst_reg : '0;
  assign o_commit_data      = w_retire ? w_head_entry.data : '0;
  assign o_valid_branch     = w_retire & w_head_entry.is_branch;
  assign o_branch_outcome   = o_valid_branch & w_head_entry.outcome;
  assign o_valid_jump_reg   = w_retire & w_head_entry.is_jump_reg;
  assign o_jump_target      = o_valid_jump_reg ? w_head_entry.target : '0;
endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench: expected commits are queued at allocation, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_rob_commit_unit;
  import mips_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_alloc_valid = 0, i_alloc_is_branch = 0, i_alloc_is_jump_reg = 0, i_alloc_dst_valid = 0;
  logic [4:0]  i_alloc_dst_reg = '0;
  logic [3:0]  o_alloc_tag;
  logic        i_wb_valid = 0;
  logic [3:0]  i_wb_tag = '0;
  logic [31:0] i_wb_data = '0;
  logic        i_wb_branch_outcome = 0;
  logic [31:0] i_wb_jump_target = '0;
  logic        i_stall = 0, i_flush = 0;
  logic        o_full, o_empty;
  logic [4:0]  o_count;
  logic        o_valid_commit, o_commit_dst_valid;
  logic [4:0]  o_commit_dst_reg;
  logic [31:0] o_commit_data;
  logic        o_valid_branch, o_branch_outcome, o_valid_jump_reg;
  logic [31:0] o_jump_target;

  always #5 clk = ~clk;

  rob_commit_unit dut (
    .clk(clk), .rst_n(rst_n),
    .i_alloc_valid(i_alloc_valid), .i_alloc_is_branch(i_alloc_is_branch),
    .i_alloc_is_jump_reg(i_alloc_is_jump_reg), .i_alloc_dst_valid(i_alloc_dst_valid),
    .i_alloc_dst_reg(i_alloc_dst_reg), .o_alloc_tag(o_alloc_tag),
    .i_wb_valid(i_wb_valid), .i_wb_tag(i_wb_tag), .i_wb_data(i_wb_data),
    .i_wb_branch_outcome(i_wb_branch_outcome), .i_wb_jump_target(i_wb_jump_target),
    .i_stall(i_stall), .i_flush(i_flush),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .o_valid_commit(o_valid_commit), .o_commit_dst_valid(o_commit_dst_valid),
    .o_commit_dst_reg(o_commit_dst_reg), .o_commit_data(o_commit_data),
    .o_valid_branch(o_valid_branch), .o_branch_outcome(o_branch_outcome),
    .o_valid_jump_reg(o_valid_jump_reg), .o_jump_target(o_jump_target)
  );

  typedef struct {
    logic        dv;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        br;
    logic        outc;
    logic        jr;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_commits = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic dv, input logic [4:0] rd, input logic [31:0] data,
                      input logic br, input logic outc, input logic jr, input logic [31:0] tgt);
    exp_t e;
    e.dv = dv; e.rd = rd; e.data = data; e.br = br; e.outc = outc; e.jr = jr; e.tgt = tgt;
    sb_q.push_back(e);
  endtask

  // Monitor: one line per retired entry, compared against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (o_valid_commit) begin
        n_commits++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: got data 'h%0h, expected no commit", o_commit_data);
        end else begin
          e = sb_q.pop_front();
          $display("commit %0d: rd=%0d dv=%0b data=%h br=%0b/%0b jr=%0b tgt=%h", n_commits,
                   o_commit_dst_reg, o_commit_dst_valid, o_commit_data, o_valid_branch,
                   o_branch_outcome, o_valid_jump_reg, o_jump_target);
          check("commit_dst_valid", o_commit_dst_valid, e.dv);
          check("commit_dst_reg", o_commit_dst_reg, e.rd);
          check("commit_data", o_commit_data, e.data);
          check("valid_branch", o_valid_branch, e.br);
          check("valid_jump_reg", o_valid_jump_reg, e.jr);
          if (e.br) check("branch_outcome", o_branch_outcome, e.outc);
          if (e.jr) check("jump_target", o_jump_target, e.tgt);
        end
      end else if (o_valid_branch || o_valid_jump_reg || o_commit_dst_valid) begin
        checks++;
        errors++;
        $display("FAIL pulse_without_commit: got br=%0b jr=%0b dv=%0b, expected 0",
                 o_valid_branch, o_valid_jump_reg, o_commit_dst_valid);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic br, input logic jr, input logic dv, input logic [4:0] rd);
    i_alloc_valid = 1'b1; i_alloc_is_branch = br; i_alloc_is_jump_reg = jr;
    i_alloc_dst_valid = dv; i_alloc_dst_reg = rd;
  endtask

  task automatic set_wb(input logic [3:0] tag, input logic [31:0] data, input logic outc,
                        input logic [31:0] tgt);
    i_wb_valid = 1'b1; i_wb_tag = tag; i_wb_data = data;
    i_wb_branch_outcome = outc; i_wb_jump_target = tgt;
  endtask

  task automatic clear_strobes();
    i_alloc_valid = 1'b0;
    i_wb_valid    = 1'b0;
    i_flush       = 1'b0;
  endtask

  task automatic alloc(input logic br, input logic jr, input logic dv, input logic [4:0] rd);
    set_alloc(br, jr, dv, rd);
    cyc();
    clear_strobes();
  endtask

  task automatic wb(input logic [3:0] tag, input logic [31:0] data, input logic outc,
                    input logic [31:0] tgt);
    set_wb(tag, data, outc, tgt);
    cyc();
    clear_strobes();
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 24 && !o_empty; k++) cyc();
    check(name, o_empty, 1'b1);
  endtask

  initial begin : watchdog
    #100000;
    errors++;
    $display("FAIL watchdog: got no completion, expected finish before 100us");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stimulus
    logic [3:0] exp_tag, cur_tag, prev_tag;
    logic       jr;
    int         n0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_empty", o_empty, 1'b1);
    check("rst_full", o_full, 1'b0);
    check("rst_count", o_count, 5'd0);
    check("rst_alloc_tag", o_alloc_tag, 4'd0);
    check("rst_valid_commit", o_valid_commit, 1'b0);

    // Out-of-order completion, in-order retirement
    check("ooo_tag0", o_alloc_tag, 4'd0);
    alloc(0, 0, 1, 5'd1); push(1, 5'd1, 32'hA0, 0, 0, 0, 32'h0);
    check("ooo_tag1", o_alloc_tag, 4'd1);
    alloc(0, 0, 1, 5'd2); push(1, 5'd2, 32'hA1, 0, 0, 0, 32'h0);
    check("ooo_tag2", o_alloc_tag, 4'd2);
    alloc(0, 0, 1, 5'd3); push(1, 5'd3, 32'hA2, 0, 0, 0, 32'h0);
    check("ooo_count", o_count, 5'd3);
    wb(4'd2, 32'hA2, 0, 32'h0);
    wb(4'd0, 32'hA0, 0, 32'h0);
    set_wb(4'd1, 32'hA1, 0, 32'h0);
    #1 check("ooo_commit0", o_valid_commit, 1'b1);
    cyc(); clear_strobes();
    #1 check("ooo_commit1", o_valid_commit, 1'b1);
    cyc();
    #1 check("ooo_commit2", o_valid_commit, 1'b1);
    cyc();
    check("ooo_empty", o_empty, 1'b1);

    // Branch held by stall: no pulse until stall drops, then exactly one
    alloc(1, 0, 0, 5'd0); push(0, 5'd0, 32'h0, 1, 1, 0, 32'h0);
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) set_wb(4'd3, 32'h0, 1'b1, 32'h0);
      #1 check("stall_no_branch", o_valid_branch, 1'b0);
      check("stall_no_commit", o_valid_commit, 1'b0);
      cyc(); clear_strobes();
    end
    i_stall = 1'b0;
    #1 check("stall_branch_pulse", o_valid_branch, 1'b1);
    check("stall_branch_outcome", o_branch_outcome, 1'b1);
    cyc();
    #1 check("stall_single_pulse", o_valid_branch, 1'b0);
    check("stall_empty", o_empty, 1'b1);

    // Full boundary: head=tail=4 here
    n0 = n_commits;
    for (int i = 0; i < 16; i++) begin
      alloc(0, 0, 1, 5'(i + 1));
      push(1, 5'(i + 1), 32'h40 + 32'(i), 0, 0, 0, 32'h0);
    end
    check("full_count16", o_count, 5'd16);
    check("full_flag", o_full, 1'b1);
    wb(4'd4, 32'h40, 0, 32'h0);
    set_alloc(0, 0, 1, 5'd30);
    #1 check("full_drop_full", o_full, 1'b1);
    check("full_drop_retire", o_valid_commit, 1'b1);
    cyc(); clear_strobes();
    check("full_after_count", o_count, 5'd15);
    check("full_after_flag", o_full, 1'b0);
    check("full_next_tag", o_alloc_tag, 4'd4);
    alloc(0, 0, 1, 5'd20); push(1, 5'd20, 32'h60, 0, 0, 0, 32'h0);
    check("full_refill_count", o_count, 5'd16);
    for (int i = 1; i < 16; i++) wb(4'((4 + i) % 16), 32'h40 + 32'(i), 0, 32'h0);
    wb(4'd4, 32'h60, 0, 32'h0);
    drain("full_drain_empty");
    check("full_commit_total", n_commits - n0, 17);

    // Wrap-around: pipelined alloc / writeback / retire, tags start at 5
    n0 = n_commits;
    exp_tag = 4'd5;
    prev_tag = 4'd0;
    cur_tag = 4'd0;
    for (int k = 0; k <= 40; k++) begin
      if (k < 40) begin
        check("wrap_tag", o_alloc_tag, exp_tag);
        jr = (k % 3 == 0);
        set_alloc(0, jr, !jr, 5'((k % 31) + 1));
        push(!jr, 5'((k % 31) + 1), 32'hB00 + 32'(k), 0, 0, jr,
             jr ? 32'h1000_0000 + 32'(4 * k) : 32'h0);
        cur_tag = exp_tag;
        exp_tag = exp_tag + 4'd1;
      end
      if (k > 0) set_wb(prev_tag, 32'hB00 + 32'(k - 1), 0, 32'h1000_0000 + 32'(4 * (k - 1)));
      cyc(); clear_strobes();
      prev_tag = cur_tag;
    end
    drain("wrap_drain_empty");
    check("wrap_commit_total", n_commits - n0, 40);

    // Flush with six live entries (tags 13..2), head is a completed jr
    alloc(0, 1, 0, 5'd0);
    for (int i = 0; i < 5; i++) alloc(0, 0, 1, 5'(i + 9));
    check("flush_pre_count", o_count, 5'd6);
    wb(4'd13, 32'h0, 0, 32'hDEAD_0000);
    set_alloc(1, 0, 0, 5'd0);
    set_wb(4'd14, 32'h77, 0, 32'h0);
    i_flush = 1'b1;
    #1 check("flush_no_commit", o_valid_commit, 1'b0);
    check("flush_no_jr", o_valid_jump_reg, 1'b0);
    cyc(); clear_strobes();
    check("flush_empty", o_empty, 1'b1);
    check("flush_count", o_count, 5'd0);
    check("flush_tag", o_alloc_tag, 4'd0);
    #1 check("flush_idle_commit", o_valid_commit, 1'b0);
    cyc();
    alloc(0, 0, 1, 5'd7); push(1, 5'd7, 32'hC0, 0, 0, 0, 32'h0);
    wb(4'd0, 32'hC0, 0, 32'h0);
    drain("flush_recover_empty");

    // Asynchronous reset with five live entries, head completed
    for (int i = 0; i < 5; i++) alloc(0, 0, 1, 5'(i + 1));
    wb(4'd1, 32'h55, 0, 32'h0);
    #2 rst_n = 1'b0;
    #1 check("arst_empty", o_empty, 1'b1);
    check("arst_full", o_full, 1'b0);
    check("arst_count", o_count, 5'd0);
    check("arst_tag", o_alloc_tag, 4'd0);
    check("arst_commit", o_valid_commit, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("arst_after_commit", o_valid_commit, 1'b0);
    cyc();
    check("arst_after_empty", o_empty, 1'b1);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
